// File: rtl/arbiter_rr_n.sv
// arbiter_rr_n: N-way round-robin arbiter with grant locking and optional hold-time preemption
module arbiter_rr_n #(
    parameter int N = 4,
    parameter int MAX_HOLD = 0,
    localparam int IDX_W = $clog2(N),
    localparam int HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     request,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             preempt
);
    logic [N-1:0]      r_grant;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  r_last;
    logic              r_valid;
    logic              r_preempt;
    logic [HOLD_W-1:0] r_hold;
    logic              w_busy;
    logic              w_at_max;
    logic              w_timeout;
    logic              w_arb;
    logic              w_found;
    logic [N-1:0]      w_mask;
    logic [IDX_W-1:0]  w_win;

    assign w_busy    = r_valid & request[r_idx];
    assign w_at_max  = (MAX_HOLD != 0) && (r_hold == HOLD_W'(MAX_HOLD));
    assign w_timeout = w_at_max & w_busy & (|(request & ~r_grant));
    assign w_arb     = ~w_busy | w_timeout;
    assign w_mask    = w_timeout ? (request & ~r_grant) : request;

    // round-robin search starting just after the last winner; lowest k wins
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_mask[(int'(r_last) + 1 + k) % N]) begin
                w_found = 1'b1;
                w_win   = IDX_W'((int'(r_last) + 1 + k) % N);
            end
        end
    end

    // grant register: hold while owner busy, re-arbitrate on release or timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant   <= '0;
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_preempt <= 1'b0;
            r_last    <= IDX_W'(N - 1);
            r_hold    <= '0;
        end else begin
            r_preempt <= w_timeout;
            if (w_arb) begin
                r_grant <= w_found ? (N'(1) << w_win) : '0;
                r_valid <= w_found;
                r_idx   <= w_found ? w_win : '0;
                if (w_found) begin
                    r_last <= w_win;
                    r_hold <= HOLD_W'(1);
                end
            end else if (MAX_HOLD != 0 && !w_at_max) begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_valid;
    assign grant_idx   = r_idx;
    assign preempt     = r_preempt;
endmodule

// File: tb/tb_arbiter_rr_n.sv
// tb_arbiter_rr_n: directed table-driven bench for the round-robin arbiter
module tb_arbiter_rr_n;
    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] idx;
        logic       valid;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [3:0] req_a, req_b;
    logic [3:0] g_a, g_b;
    logic       v_a, v_b, p_a, p_b;
    logic [1:0] i_a, i_b;
    int         total = 0;
    int         bad = 0;
    vec_t       tbl[15];

    arbiter_rr_n #(.N(4), .MAX_HOLD(0)) dut_a (
        .clk(clk), .rst(rst), .request(req_a), .grant(g_a),
        .grant_valid(v_a), .grant_idx(i_a), .preempt(p_a)
    );

    arbiter_rr_n #(.N(4), .MAX_HOLD(8)) dut_b (
        .clk(clk), .rst(rst), .request(req_b), .grant(g_b),
        .grant_valid(v_b), .grant_idx(i_b), .preempt(p_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("onehot0_a", 32'($onehot0(g_a)), 1);
            chk("valid_a", 32'(v_a), 32'(|g_a));
            chk("idxmatch_a", g_a, v_a ? (4'b1 << i_a) : 4'b0);
            chk("onehot0_b", 32'($onehot0(g_b)), 1);
            chk("valid_b", 32'(v_b), 32'(|g_b));
            chk("idxmatch_b", g_b, v_b ? (4'b1 << i_b) : 4'b0);
        end
    end

    initial begin
        tbl[0]  = '{4'b1111, 4'b0001, 2'd0, 1'b1};
        tbl[1]  = '{4'b1110, 4'b0010, 2'd1, 1'b1};
        tbl[2]  = '{4'b1101, 4'b0100, 2'd2, 1'b1};
        tbl[3]  = '{4'b1011, 4'b1000, 2'd3, 1'b1};
        tbl[4]  = '{4'b0111, 4'b0001, 2'd0, 1'b1};
        tbl[5]  = '{4'b1010, 4'b0010, 2'd1, 1'b1};
        tbl[6]  = '{4'b1010, 4'b0010, 2'd1, 1'b1};
        tbl[7]  = '{4'b1000, 4'b1000, 2'd3, 1'b1};
        tbl[8]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[9]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};
        tbl[10] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[11] = '{4'b1001, 4'b1000, 2'd3, 1'b1};
        tbl[12] = '{4'b1001, 4'b1000, 2'd3, 1'b1};
        tbl[13] = '{4'b0001, 4'b0001, 2'd0, 1'b1};
        tbl[14] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        rst   = 1'b1;
        req_a = 4'b0;
        req_b = 4'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant_a", g_a, 0);
        chk("rst_valid_a", v_a, 0);
        chk("rst_idx_a", i_a, 0);
        chk("rst_preempt_a", p_a, 0);
        chk("rst_grant_b", g_b, 0);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            req_a = tbl[i].req;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_grant", i), g_a, tbl[i].grant);
            chk($sformatf("tbl%0d_idx", i), i_a, tbl[i].idx);
            chk($sformatf("tbl%0d_valid", i), v_a, tbl[i].valid);
            chk($sformatf("tbl%0d_preempt", i), p_a, 0);
        end
        req_a = 4'b0100;
        @(posedge clk);
        #1;
        chk("single_grant", g_a, 4'b0100);
        chk("single_idx", i_a, 2);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            chk("single_hold", g_a, 4'b0100);
        end
        #2 rst = 1'b1;
        #1;
        chk("async_rst_grant", g_a, 0);
        chk("async_rst_valid", v_a, 0);
        req_a = 4'b1010;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_idx", i_a, 1);
        chk("post_rst_grant", g_a, 4'b0010);
        req_a = 4'b0;
        req_b = 4'b0001;
        @(posedge clk);
        #1;
        chk("solo_grant", g_b, 4'b0001);
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            chk("solo_hold", g_b, 4'b0001);
            chk("solo_no_preempt", p_b, 0);
        end
        req_b = 4'b0;
        @(posedge clk);
        #1;
        chk("solo_release", g_b, 0);
        req_b = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("own%0d_grant", c), g_b, 4'b0001);
            chk($sformatf("own%0d_preempt", c), p_b, 0);
            if (c == 3) req_b = 4'b0101;
        end
        @(posedge clk);
        #1;
        chk("preempt_pulse", p_b, 1);
        chk("preempt_grant", g_b, 4'b0100);
        chk("preempt_idx", i_b, 2);
        @(posedge clk);
        #1;
        chk("preempt_end", p_b, 0);
        chk("preempt_keep", g_b, 4'b0100);
        req_b = 4'b0001;
        @(posedge clk);
        #1;
        chk("preempted_back", g_b, 4'b0001);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
